// File: rtl/instruction_prefetch.sv
// Instruction prefetch queue: keeps up to DEPTH words fetched ahead; optional stall counter under PF_STALL_COUNT_EN.
// Fetch-to-valid latency 2 cycles minimum; stops requesting when the queue is full, a branch flushes and redirects.
module instruction_prefetch #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int ADDRESS_WIDTH     = 11,
    parameter int DEPTH             = 4
) (
    input  logic                         clock,
    input  logic                         pf_reset_n,
    output logic                         pf_mem_req,
    output logic [ADDRESS_WIDTH-1:0]     pf_mem_addr,
    input  logic                         pf_mem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] pf_mem_data,
    input  logic                         pf_take,
    output logic [INSTRUCTION_WIDTH-1:0] pf_out,
    output logic [ADDRESS_WIDTH-1:0]     pf_out_pc,
    output logic                         pf_valid,
    input  logic                         pf_branch,
    input  logic [ADDRESS_WIDTH-1:0]     pf_branch_addr
`ifdef PF_STALL_COUNT_EN
    ,
    output logic [15:0]                  pf_stall_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDRESS_WIDTH-1:0] ptr_inc;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     push;
    logic                     pop;

    logic [INSTRUCTION_WIDTH-1:0] data_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0]     pc_q   [DEPTH];

    assign pf_valid    = (count_q != '0);
    assign pop         = pf_take && pf_valid && !pf_branch;
    assign ptr_inc     = fetch_ptr_q + ADDRESS_WIDTH'(1);
    assign pf_mem_req  = (state_q != IDLE);
    assign pf_mem_addr = pf_mem_req ? req_addr_q : '0;
    assign pf_out      = pf_valid ? data_q[rd_ptr_q] : '0;
    assign pf_out_pc   = pf_valid ? pc_q[rd_ptr_q] : '0;

    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        req_addr_d  = req_addr_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pf_branch) begin
                    fetch_ptr_d = pf_branch_addr;
                end else if (count_q != CNT_W'(DEPTH)) begin
                    state_d    = FETCH;
                    req_addr_d = fetch_ptr_q;
                end
            end
            FETCH: begin
                if (pf_branch) begin
                    fetch_ptr_d = pf_branch_addr;
                    if (pf_mem_ack) begin
                        req_addr_d = pf_branch_addr;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (pf_mem_ack) begin
                    push        = 1'b1;
                    fetch_ptr_d = ptr_inc;
                    // Only an ack into the last free slot without a simultaneous pop fills the queue.
                    if (count_q == CNT_W'(DEPTH - 1) && !pop) begin
                        state_d = IDLE;
                    end else begin
                        req_addr_d = ptr_inc;
                    end
                end
            end
            DISCARD: begin
                if (pf_branch) begin
                    fetch_ptr_d = pf_branch_addr;
                end
                if (pf_mem_ack) begin
                    state_d    = FETCH;
                    req_addr_d = pf_branch ? pf_branch_addr : fetch_ptr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pf_branch) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge pf_reset_n) begin
        if (!pf_reset_n) begin
            state_q     <= IDLE;
            fetch_ptr_q <= '0;
            req_addr_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            req_addr_q  <= req_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: pf_valid gates everything read out of it.
    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr_q] <= pf_mem_data;
            pc_q[wr_ptr_q]   <= req_addr_q;
        end
    end

`ifdef PF_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock or negedge pf_reset_n) begin
        if (!pf_reset_n) begin
            stall_q <= '0;
        end else if (pf_branch) begin
            stall_q <= '0;
        end else if (pf_take && !pf_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign pf_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: hand-computed expectations checked with immediate assertions.
module tb_instruction_prefetch;

    logic        clock = 1'b0;
    logic        pf_reset_n;
    logic        pf_mem_req;
    logic [10:0] pf_mem_addr;
    logic        pf_mem_ack;
    logic [15:0] pf_mem_data;
    logic        pf_take;
    logic [15:0] pf_out;
    logic [10:0] pf_out_pc;
    logic        pf_valid;
    logic        pf_branch;
    logic [10:0] pf_branch_addr;
`ifdef PF_STALL_COUNT_EN
    logic [15:0] pf_stall_count;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    instruction_prefetch #(
        .INSTRUCTION_WIDTH(16),
        .ADDRESS_WIDTH(11),
        .DEPTH(4)
    ) dut (
        .clock(clock),
        .pf_reset_n(pf_reset_n),
        .pf_mem_req(pf_mem_req),
        .pf_mem_addr(pf_mem_addr),
        .pf_mem_ack(pf_mem_ack),
        .pf_mem_data(pf_mem_data),
        .pf_take(pf_take),
        .pf_out(pf_out),
        .pf_out_pc(pf_out_pc),
        .pf_valid(pf_valid),
        .pf_branch(pf_branch),
        .pf_branch_addr(pf_branch_addr)
`ifdef PF_STALL_COUNT_EN
        ,
        .pf_stall_count(pf_stall_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] word(input logic [10:0] a);
        return 16'hC000 | {5'b0, a};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request served with ack in the cycle after it appears.
    task automatic fetch_one(input logic [10:0] a);
        check("req_up", 32'(pf_mem_req), 32'd1);
        check("req_addr", 32'(pf_mem_addr), 32'(a));
        tick();
        check("addr_hold", 32'(pf_mem_addr), 32'(a));
        pf_mem_ack  = 1'b1;
        pf_mem_data = word(a);
        tick();
        pf_mem_ack  = 1'b0;
        pf_mem_data = '0;
    endtask

    initial begin
        pf_reset_n     = 1'b0;
        pf_mem_ack     = 1'b0;
        pf_mem_data    = '0;
        pf_take        = 1'b0;
        pf_branch      = 1'b0;
        pf_branch_addr = '0;
        tick();
        tick();
        check("rst_req", 32'(pf_mem_req), 32'd0);
        check("rst_addr", 32'(pf_mem_addr), 32'd0);
        check("rst_valid", 32'(pf_valid), 32'd0);
        check("rst_out", 32'(pf_out), 32'd0);
        check("rst_pc", 32'(pf_out_pc), 32'd0);

        // Fill from reset: addresses 0..3, then stop with 4 entries.
        pf_reset_n = 1'b1;
        #1;
        check("rel_req_low", 32'(pf_mem_req), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) fetch_one(11'(i));
        check("full_req", 32'(pf_mem_req), 32'd0);
        check("full_valid", 32'(pf_valid), 32'd1);
        check("full_out", 32'(pf_out), 32'hC000);
        check("full_pc", 32'(pf_out_pc), 32'd0);
        tick();
        check("full_idle", 32'(pf_mem_req), 32'd0);

        // Take twice from a full queue; refetch 4 and 5.
        pf_take = 1'b1;
        tick();
        check("take1_pc", 32'(pf_out_pc), 32'd1);
        check("take1_out", 32'(pf_out), 32'hC001);
        check("take1_req", 32'(pf_mem_req), 32'd0);
        tick();
        pf_take = 1'b0;
        check("take2_pc", 32'(pf_out_pc), 32'd2);
        fetch_one(11'd4);
        fetch_one(11'd5);
        check("refill_req", 32'(pf_mem_req), 32'd0);
        check("refill_pc", 32'(pf_out_pc), 32'd2);

        // Drain: exactly four entries 2..5.
        pf_take = 1'b1;
        for (int i = 3; i < 6; i++) begin
            tick();
            check("drain_pc", 32'(pf_out_pc), 32'(i));
            check("drain_out", 32'(pf_out), 32'hC000 + 32'(i));
        end
        tick();
        pf_take = 1'b0;
        check("drain_empty", 32'(pf_valid), 32'd0);
        check("drain_out0", 32'(pf_out), 32'd0);
        check("drain_req6", 32'(pf_mem_addr), 32'd6);

        // Reset in the middle of the outstanding request to 6.
        pf_reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(pf_mem_req), 32'd0);
        check("mid_rst_addr", 32'(pf_mem_addr), 32'd0);
        tick();
        pf_reset_n = 1'b1;
        tick();
        fetch_one(11'd0);
        fetch_one(11'd1);

        // Branch while request to 2 outstanding; ack 3 cycles later is dropped.
        pf_branch      = 1'b1;
        pf_branch_addr = 11'h100;
        tick();
        pf_branch = 1'b0;
        check("disc_req", 32'(pf_mem_req), 32'd1);
        check("disc_addr", 32'(pf_mem_addr), 32'd2);
        check("disc_valid", 32'(pf_valid), 32'd0);
        tick();
        tick();
        check("disc_hold", 32'(pf_mem_addr), 32'd2);
        pf_mem_ack  = 1'b1;
        pf_mem_data = word(11'd2);
        tick();
        pf_mem_ack = 1'b0;
        check("redir_addr", 32'(pf_mem_addr), 32'h100);
        check("redir_valid", 32'(pf_valid), 32'd0);
        fetch_one(11'h100);
        check("redir_pc", 32'(pf_out_pc), 32'h100);
        check("redir_out", 32'(pf_out), 32'hC100);

        // Simultaneous push and pop with 2 entries.
        fetch_one(11'h101);
        tick();
        pf_mem_ack  = 1'b1;
        pf_mem_data = word(11'h102);
        pf_take     = 1'b1;
        tick();
        pf_mem_ack = 1'b0;
        check("pp_pc", 32'(pf_out_pc), 32'h101);
        check("pp_out", 32'(pf_out), 32'hC101);
        check("pp_addr", 32'(pf_mem_addr), 32'h103);
        tick();
        check("pp_pc2", 32'(pf_out_pc), 32'h102);
        check("pp_out2", 32'(pf_out), 32'hC102);
        tick();
        pf_take = 1'b0;
        check("pp_empty", 32'(pf_valid), 32'd0);

        // Branch with ack in FETCH to 0x7FF, then wrap to 0x000.
        pf_branch      = 1'b1;
        pf_branch_addr = 11'h7FF;
        pf_mem_ack     = 1'b1;
        pf_mem_data    = 16'hDEAD;
        tick();
        pf_branch  = 1'b0;
        pf_mem_ack = 1'b0;
        check("bra_valid", 32'(pf_valid), 32'd0);
        fetch_one(11'h7FF);
        check("wrap_pc", 32'(pf_out_pc), 32'h7FF);
        check("wrap_out", 32'(pf_out), 32'hC7FF);
        check("wrap_addr", 32'(pf_mem_addr), 32'h000);

        // Second branch while discarding only reloads the pointer.
        pf_branch      = 1'b1;
        pf_branch_addr = 11'h200;
        tick();
        check("d2_addr", 32'(pf_mem_addr), 32'h000);
        check("d2_valid", 32'(pf_valid), 32'd0);
        pf_branch_addr = 11'h300;
        tick();
        pf_branch = 1'b0;
        check("d2_hold", 32'(pf_mem_addr), 32'h000);
        pf_mem_ack  = 1'b1;
        pf_mem_data = word(11'h0);
        tick();
        pf_mem_ack = 1'b0;
        check("d2_new_addr", 32'(pf_mem_addr), 32'h300);
        check("d2_new_valid", 32'(pf_valid), 32'd0);

        // Take on an empty queue is ignored.
        pf_take = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        pf_take = 1'b0;
        check("stall_valid", 32'(pf_valid), 32'd0);
        check("stall_addr", 32'(pf_mem_addr), 32'h300);
`ifdef PF_STALL_COUNT_EN
        check("stall_cnt5", 32'(pf_stall_count), 32'd5);
        pf_branch      = 1'b1;
        pf_branch_addr = 11'h010;
        tick();
        pf_branch = 1'b0;
        check("stall_clr", 32'(pf_stall_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 Parameters SHALL be: INSTRUCTION_WIDTH, default 16, instruction word width; ADDRESS_WIDTH, default 11, word address width; DEPTH, default 4 (power of two, >=2), prefetch queue entries.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 pf_reset_n  input  1  asynchronous active-low reset.
REQ-005 pf_mem_req  output  1  instruction memory read request.
REQ-006 pf_mem_addr  output  ADDRESS_WIDTH  read address, valid while pf_mem_req=1.
REQ-007 pf_mem_ack  input  1  memory has returned pf_mem_data this cycle.
REQ-008 pf_mem_data  input  INSTRUCTION_WIDTH  returned instruction word.
REQ-009 pf_take  input  1  consumer (instruction register write strobe) pops the head entry.
REQ-010 pf_out  output  INSTRUCTION_WIDTH  head instruction, drives the instruction register data input.
REQ-011 pf_out_pc  output  ADDRESS_WIDTH  address of the head instruction.
REQ-012 pf_valid  output  1  queue non-empty; pf_out/pf_out_pc meaningful.
REQ-013 pf_branch  input  1  redirect: flush queue, restart fetch at pf_branch_addr.
REQ-014 pf_branch_addr  input  ADDRESS_WIDTH  redirect target.

Function
REQ-015 FSM states SHALL be IDLE (no request outstanding), FETCH (pf_mem_req=1, awaiting ack), DISCARD (request outstanding whose data is to be dropped).
REQ-016 IDLE->FETCH when the queue holds fewer than DEPTH entries and pf_branch=0; pf_mem_addr = fetch pointer.
REQ-017 In FETCH and DISCARD, pf_mem_req and pf_mem_addr SHALL remain stable until the pf_mem_ack cycle.
REQ-018 FETCH with ack: the word and its address SHALL be pushed at the tail, fetch pointer +1 modulo 2^ADDRESS_WIDTH; next state FETCH if a free slot remains after this cycle's push/pop, else IDLE.
REQ-019 A request SHALL never be issued when the queue is full, so a push into a full queue is impossible.
REQ-020 pf_take with pf_valid=1 SHALL pop the head at the clock edge; pf_take with pf_valid=0 SHALL be ignored.
REQ-021 Push and pop in the same cycle SHALL leave the count unchanged and both take effect.
REQ-022 pf_out SHALL present the head combinationally from queue storage; an acked word becomes visible on pf_out one cycle after ack (minimum fetch-to-valid latency 2 cycles from request).
REQ-023 pf_branch=1 SHALL, at the edge: empty the queue, load the fetch pointer with pf_branch_addr, ignore pf_take and drop any ack data that cycle.
REQ-024 pf_branch in FETCH without ack SHALL move to DISCARD; in DISCARD, ack SHALL drop the data and go to FETCH at the new pointer without incrementing it.
REQ-025 pf_branch in DISCARD SHALL only reload the fetch pointer; pf_branch with ack in FETCH/DISCARD SHALL go to FETCH at pf_branch_addr.
REQ-026 Queue read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-027 pf_reset_n=0 SHALL asynchronously set state IDLE, fetch pointer 0, queue empty, pf_mem_req=0, pf_valid=0, pf_mem_addr=0, pf_out=0, pf_out_pc=0.
REQ-028 Reset asserted mid-request SHALL abandon the request; first request after release SHALL be address 0 on the cycle after the first edge with pf_reset_n=1.

Configuration
REQ-029 Macro PF_STALL_COUNT_EN, when defined, SHALL add output pf_stall_count (16 bits) counting cycles with pf_take=1 and pf_valid=0, saturating at 16'hFFFF, cleared by reset and by pf_branch.
REQ-030 Without PF_STALL_COUNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset release, ack 1 cycle after every request, no take -> requests to addresses 0,1,2,3, then pf_mem_req=0 with 4 entries; pf_out=word@0, pf_out_pc=0.
REQ-032 Full queue, pf_take held 2 cycles -> pf_out_pc steps 1,2; new requests to 4 and 5 issued, count never exceeds 4.
REQ-033 Request to 2 outstanding, pf_branch with addr 0x100, ack 3 cycles later -> data dropped, next request addr 0x100, pf_valid=0 until that word returns.
REQ-034 Fetch pointer 0x7FF, ack -> next request address 0x000.
REQ-035 Push and pop in same cycle with 2 entries -> count stays 2, order preserved.
REQ-036 With PF_STALL_COUNT_EN, pf_take=1 for 5 cycles on empty queue -> pf_stall_count=5; pf_branch -> 0.
